// File: rtl/reaction_stats_if.sv
// Bundle of the score-keeping stage's timer inputs, controls and display outputs.
interface reaction_stats_if;
  logic       start;
  logic       led;
  logic       measure_q;
  logic       error_q;
  logic       ceo;
  logic [3:0] q2, q1, q0;
  logic       clear_stats;
  logic       show_best;
  logic [3:0] last2, last1, last0;
  logic [3:0] best2, best1, best0;
  logic       best_valid;
  logic [3:0] trials1, trials0;
  logic [3:0] errors1, errors0;
  logic       new_best;
  logic [3:0] disp2, disp1, disp0;
  logic       busy;

  modport master (
    output start, led, measure_q, error_q, ceo, q2, q1, q0, clear_stats, show_best,
    input  last2, last1, last0, best2, best1, best0, best_valid,
           trials1, trials0, errors1, errors0, new_best, disp2, disp1, disp0, busy
  );

  modport slave (
    input  start, led, measure_q, error_q, ceo, q2, q1, q0, clear_stats, show_best,
    output last2, last1, last0, best2, best1, best0, best_valid,
           trials1, trials0, errors1, errors0, new_best, disp2, disp1, disp0, busy
  );
endinterface

// File: rtl/reaction_stats.sv
// Reaction-timer statistics: latches the last valid time, tracks the best
// (minimum) time, counts valid trials and false starts in saturating BCD.
module reaction_stats #(
  parameter int unsigned SAT_COUNT = 99
) (
  input  logic             clk,
  input  logic             reset,
  reaction_stats_if.slave  bus
);

  localparam logic [3:0] SAT1 = 4'(SAT_COUNT / 10);
  localparam logic [3:0] SAT0 = 4'(SAT_COUNT % 10);

  typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, COMMIT, HOLD} state_t;

  state_t          state_q, state_d;
  logic            meas_prev_q, err_prev_q;
  logic            ovf_q;
  logic [2:0][3:0] last_q, best_q;
  logic            best_valid_q, new_best_q;
  logic [7:0]      trials_q, errors_q;

  logic            meas_rise, err_rise, fault_evt, better;
  logic            do_capture, do_commit, do_error, ovf_clr;
  logic [2:0][3:0] raw_digits, clamp_digits, capture_val;

  // Two-digit BCD increment that sticks at the saturation value.
  function automatic logic [7:0] bcd_inc(input logic [7:0] c);
    if (c == {SAT1, SAT0})     return c;
    else if (c[3:0] == 4'd9)   return {c[7:4] + 4'd1, 4'd0};
    else                       return {c[7:4], c[3:0] + 4'd1};
  endfunction

  assign meas_rise = bus.measure_q & ~meas_prev_q;
  assign err_rise  = bus.error_q & ~err_prev_q;
  // A stop before the LED lit is scored exactly like a flagged false start.
  assign fault_evt = err_rise | (meas_rise & ~bus.led);
  // Digits are clamped to 0..9, so the packed 12-bit compare is a BCD magnitude compare.
  assign better    = ~best_valid_q | (last_q < best_q);

  assign raw_digits = {bus.q2, bus.q1, bus.q0};
  for (genvar gi = 0; gi < 3; gi++) begin : g_clamp
    assign clamp_digits[gi] = (raw_digits[gi] > 4'd9) ? 4'd9 : raw_digits[gi];
  end
  assign capture_val = ovf_q ? {4'd9, 4'd9, 4'd9} : clamp_digits;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and per-cycle action strobes; start always takes priority.
  always_comb begin
    state_d    = state_q;
    do_capture = 1'b0;
    do_commit  = 1'b0;
    do_error   = 1'b0;
    ovf_clr    = 1'b0;
    case (state_q)
      IDLE, HOLD: begin
        if (bus.start) begin
          state_d = ARMED;
          ovf_clr = 1'b1;
        end
      end
      ARMED: begin
        if (bus.start) begin
          ovf_clr = 1'b1;
        end else if (fault_evt) begin
          do_error = 1'b1;
          state_d  = HOLD;
        end else if (meas_rise) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (bus.start) begin
          state_d = ARMED;
          ovf_clr = 1'b1;
        end else begin
          do_capture = 1'b1;
          state_d    = COMMIT;
        end
      end
      COMMIT: begin
        if (bus.start) begin
          state_d = ARMED;
          ovf_clr = 1'b1;
        end else begin
          do_commit = 1'b1;
          state_d   = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Edge registers, overflow flag and statistics; clear_stats beats any update.
  always_ff @(posedge clk) begin
    if (reset) begin
      meas_prev_q  <= 1'b0;
      err_prev_q   <= 1'b0;
      ovf_q        <= 1'b0;
      last_q       <= '0;
      best_q       <= '0;
      best_valid_q <= 1'b0;
      new_best_q   <= 1'b0;
      trials_q     <= '0;
      errors_q     <= '0;
    end else begin
      meas_prev_q <= bus.measure_q;
      err_prev_q  <= bus.error_q;
      new_best_q  <= 1'b0;
      if (ovf_clr)                         ovf_q <= 1'b0;
      else if (state_q == ARMED && bus.ceo) ovf_q <= 1'b1;
      if (bus.clear_stats) begin
        last_q       <= '0;
        best_q       <= '0;
        best_valid_q <= 1'b0;
        trials_q     <= '0;
        errors_q     <= '0;
      end else begin
        if (do_capture) last_q <= capture_val;
        if (do_commit) begin
          trials_q <= bcd_inc(trials_q);
          if (better) begin
            best_q       <= last_q;
            best_valid_q <= 1'b1;
            new_best_q   <= 1'b1;
          end
        end
        if (do_error) errors_q <= bcd_inc(errors_q);
      end
    end
  end

  // Display select between last and best time.
  always_comb begin
    {bus.disp2, bus.disp1, bus.disp0} = bus.show_best ? best_q : last_q;
  end

  assign {bus.last2, bus.last1, bus.last0} = last_q;
  assign {bus.best2, bus.best1, bus.best0} = best_q;
  assign bus.best_valid = best_valid_q;
  assign {bus.trials1, bus.trials0} = trials_q;
  assign {bus.errors1, bus.errors0} = errors_q;
  assign bus.new_best = new_best_q;
  assign bus.busy = (state_q == ARMED) || (state_q == CAPTURE) || (state_q == COMMIT);

endmodule

// File: tb/tb_reaction_stats.sv
// Randomised self-checking bench for reaction_stats against an integer score model.
module tb_reaction_stats;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reaction_stats_if bus ();
  reaction_stats #(.SAT_COUNT(99)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int n_checks = 0;
  int n_fail   = 0;

  // Score model kept as plain integers.
  int m_last, m_best, m_trials, m_errors;
  bit m_bv;

  // Observations captured by run_trial.
  logic [11:0] o_last, o_best;
  logic [7:0]  o_trials;
  logic        o_bv, o_nb1, o_nb2, o_nb3, o_nb4, o_busy1, o_busy3;

  function automatic logic [11:0] to_bcd3(input int v);
    logic [11:0] r;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [7:0] to_bcd2(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [11:0] last_bits();  return {bus.last2, bus.last1, bus.last0}; endfunction
  function automatic logic [11:0] best_bits();  return {bus.best2, bus.best1, bus.best0}; endfunction
  function automatic logic [11:0] disp_bits();  return {bus.disp2, bus.disp1, bus.disp0}; endfunction
  function automatic logic [7:0]  trial_bits(); return {bus.trials1, bus.trials0}; endfunction
  function automatic logic [7:0]  error_bits(); return {bus.errors1, bus.errors0}; endfunction

  function automatic void model_clear();
    m_last = 0; m_best = 0; m_trials = 0; m_errors = 0; m_bv = 0;
  endfunction

  // A valid trial: returns whether it should produce a new best.
  function automatic bit model_valid(input int d2, input int d1, input int d0, input bit ovf);
    int v;
    bit nb;
    v = ovf ? 999 : ((d2 > 9 ? 9 : d2) * 100 + (d1 > 9 ? 9 : d1) * 10 + (d0 > 9 ? 9 : d0));
    m_last = v;
    nb = !m_bv || (v < m_best);
    if (nb) begin m_best = v; m_bv = 1; end
    m_trials = (m_trials < 99) ? m_trials + 1 : 99;
    return nb;
  endfunction

  function automatic void model_error();
    m_errors = (m_errors < 99) ? m_errors + 1 : 99;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_trial();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Full valid trial; records observations at T+1..T+4.
  task automatic run_trial(input int d2, input int d1, input int d0, input bit with_ceo);
    start_trial();
    bus.led = 1'b1;
    bus.q2 = 4'(d2); bus.q1 = 4'(d1); bus.q0 = 4'(d0);
    if (with_ceo) begin bus.ceo = 1'b1; tick(); bus.ceo = 1'b0; end
    tick();
    bus.measure_q = 1'b1;
    tick();
    o_busy1 = bus.busy; o_nb1 = bus.new_best;
    tick();
    o_last = last_bits(); o_nb2 = bus.new_best;
    tick();
    o_best = best_bits(); o_bv = bus.best_valid; o_trials = trial_bits();
    o_nb3 = bus.new_best; o_busy3 = bus.busy;
    tick();
    o_nb4 = bus.new_best;
    bus.measure_q = 1'b0;
    bus.led = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    bus.start = 0; bus.led = 0; bus.measure_q = 0; bus.error_q = 0; bus.ceo = 0;
    bus.q2 = 0; bus.q1 = 0; bus.q0 = 0; bus.clear_stats = 0; bus.show_best = 0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    model_clear();
    n_checks++; if ({last_bits(), best_bits(), disp_bits()} !== 36'h0) begin n_fail++; $display("FAIL reset_digits got=%h exp=0", {last_bits(), best_bits(), disp_bits()}); end
    n_checks++; if ({trial_bits(), error_bits()} !== 16'h0) begin n_fail++; $display("FAIL reset_counts got=%h exp=0", {trial_bits(), error_bits()}); end
    n_checks++; if ({bus.best_valid, bus.new_best, bus.busy} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {bus.best_valid, bus.new_best, bus.busy}); end
  endtask

  task automatic test_first_trial();
    bit nb;
    run_trial(2, 3, 4, 0);
    nb = model_valid(2, 3, 4, 0);
    n_checks++; if (o_busy1 !== 1'b1) begin n_fail++; $display("FAIL first_busy_t1 got=%b exp=1", o_busy1); end
    n_checks++; if (o_last !== to_bcd3(m_last)) begin n_fail++; $display("FAIL first_last got=%h exp=%h", o_last, to_bcd3(m_last)); end
    n_checks++; if (o_best !== to_bcd3(m_best)) begin n_fail++; $display("FAIL first_best got=%h exp=%h", o_best, to_bcd3(m_best)); end
    n_checks++; if (o_bv !== m_bv) begin n_fail++; $display("FAIL first_best_valid got=%b exp=%b", o_bv, m_bv); end
    n_checks++; if (o_trials !== to_bcd2(m_trials)) begin n_fail++; $display("FAIL first_trials got=%h exp=%h", o_trials, to_bcd2(m_trials)); end
    n_checks++; if ({o_nb1, o_nb2, o_nb3, o_nb4} !== {2'b00, nb, 1'b0}) begin n_fail++; $display("FAIL first_new_best got=%b exp=%b", {o_nb1, o_nb2, o_nb3, o_nb4}, {2'b00, nb, 1'b0}); end
    n_checks++; if (o_busy3 !== 1'b0) begin n_fail++; $display("FAIL first_hold_busy got=%b exp=0", o_busy3); end
    bus.show_best = 1'b1; #1;
    n_checks++; if (disp_bits() !== to_bcd3(m_best)) begin n_fail++; $display("FAIL disp_best got=%h exp=%h", disp_bits(), to_bcd3(m_best)); end
    bus.show_best = 1'b0; #1;
    n_checks++; if (disp_bits() !== to_bcd3(m_last)) begin n_fail++; $display("FAIL disp_last got=%h exp=%h", disp_bits(), to_bcd3(m_last)); end
    $display("trial 2,3,4 last=%h best=%h trials=%h", o_last, o_best, o_trials);
  endtask

  task automatic test_best_tie();
    bit nb;
    for (int k = 0; k < 2; k++) begin
      run_trial(1, 9, 9, 0);
      nb = model_valid(1, 9, 9, 0);
      n_checks++; if (o_best !== to_bcd3(m_best)) begin n_fail++; $display("FAIL tie_best[%0d] got=%h exp=%h", k, o_best, to_bcd3(m_best)); end
      n_checks++; if ({o_nb3, o_nb4} !== {nb, 1'b0}) begin n_fail++; $display("FAIL tie_new_best[%0d] got=%b exp=%b", k, {o_nb3, o_nb4}, {nb, 1'b0}); end
      n_checks++; if (o_trials !== to_bcd2(m_trials)) begin n_fail++; $display("FAIL tie_trials[%0d] got=%h exp=%h", k, o_trials, to_bcd2(m_trials)); end
      $display("trial 1,9,9 #%0d best=%h new_best=%b trials=%h", k, o_best, o_nb3, o_trials);
    end
  endtask

  // One false start: kind 0 = early stop (led low), kind 1 = error_q rise.
  task automatic false_start(input int kind, input string tag);
    start_trial();
    bus.led = 1'b0;
    tick();
    if (kind == 0) bus.measure_q = 1'b1; else bus.error_q = 1'b1;
    tick();
    model_error();
    n_checks++; if (error_bits() !== to_bcd2(m_errors)) begin n_fail++; $display("FAIL %s_errors got=%h exp=%h", tag, error_bits(), to_bcd2(m_errors)); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL %s_hold got=%b exp=0", tag, bus.busy); end
    n_checks++; if ({last_bits(), best_bits(), trial_bits()} !== {to_bcd3(m_last), to_bcd3(m_best), to_bcd2(m_trials)}) begin n_fail++; $display("FAIL %s_stats got=%h exp=%h", tag, {last_bits(), best_bits(), trial_bits()}, {to_bcd3(m_last), to_bcd3(m_best), to_bcd2(m_trials)}); end
    $display("false start kind=%0d errors=%h", kind, error_bits());
    bus.measure_q = 1'b0; bus.error_q = 1'b0;
    tick();
  endtask

  task automatic test_errors();
    false_start(0, "early_stop");
    false_start(1, "error_rise");
  endtask

  task automatic test_overflow();
    bit nb;
    run_trial(0, 1, 2, 1);
    nb = model_valid(0, 1, 2, 1);
    n_checks++; if (o_last !== to_bcd3(m_last)) begin n_fail++; $display("FAIL ovf_last got=%h exp=%h", o_last, to_bcd3(m_last)); end
    n_checks++; if ({o_nb3, o_best} !== {nb, to_bcd3(m_best)}) begin n_fail++; $display("FAIL ovf_best got=%h exp=%h", {o_nb3, o_best}, {nb, to_bcd3(m_best)}); end
    $display("overflow trial last=%h best=%h", o_last, o_best);
  endtask

  task automatic test_start_priority();
    start_trial();
    bus.led = 1'b1; bus.q2 = 4'd0; bus.q1 = 4'd5; bus.q0 = 4'd0;
    tick();
    bus.measure_q = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    n_checks++; if ({bus.busy, trial_bits(), last_bits()} !== {1'b1, to_bcd2(m_trials), to_bcd3(m_last)}) begin n_fail++; $display("FAIL start_wins got=%h exp=%h", {bus.busy, trial_bits(), last_bits()}, {1'b1, to_bcd2(m_trials), to_bcd3(m_last)}); end
    $display("start+stop same cycle busy=%b trials=%h", bus.busy, trial_bits());
    bus.measure_q = 1'b0; bus.led = 1'b0;
    tick();
  endtask

  task automatic test_random();
    bit nb;
    int kind, d2, d1, d0;
    bit c;
    for (int i = 0; i < 20; i++) begin
      kind = $urandom_range(0, 3);
      if (kind >= 2) begin
        d2 = $urandom_range(0, 15); d1 = $urandom_range(0, 15); d0 = $urandom_range(0, 15);
        c = ($urandom_range(0, 3) == 0);
        run_trial(d2, d1, d0, c);
        nb = model_valid(d2, d1, d0, c);
        n_checks++; if ({o_last, o_best, o_trials, o_nb3} !== {to_bcd3(m_last), to_bcd3(m_best), to_bcd2(m_trials), nb}) begin n_fail++; $display("FAIL rand_trial[%0d] got=%h exp=%h", i, {o_last, o_best, o_trials, o_nb3}, {to_bcd3(m_last), to_bcd3(m_best), to_bcd2(m_trials), nb}); end
        $display("rand %0d valid digits=%0d,%0d,%0d ceo=%b last=%h best=%h nb=%b", i, d2, d1, d0, c, o_last, o_best, o_nb3);
      end else begin
        false_start(kind, "rand_fault");
      end
    end
  endtask

  task automatic test_saturation();
    bit nb;
    int d2, d1, d0;
    bus.clear_stats = 1'b1; tick(); bus.clear_stats = 1'b0;
    model_clear();
    n_checks++; if ({last_bits(), best_bits(), trial_bits(), error_bits(), bus.best_valid} !== 57'h0) begin n_fail++; $display("FAIL clear_idle got=%h exp=0", {last_bits(), best_bits(), trial_bits(), error_bits(), bus.best_valid}); end
    for (int i = 0; i < 100; i++) begin
      d2 = $urandom_range(0, 9); d1 = $urandom_range(0, 9); d0 = $urandom_range(0, 9);
      run_trial(d2, d1, d0, 0);
      nb = model_valid(d2, d1, d0, 0);
      n_checks++; if ({o_trials, o_best, o_nb3} !== {to_bcd2(m_trials), to_bcd3(m_best), nb}) begin n_fail++; $display("FAIL sat_trial[%0d] got=%h exp=%h", i, {o_trials, o_best, o_nb3}, {to_bcd2(m_trials), to_bcd3(m_best), nb}); end
      if (i >= 97) $display("sat trial %0d trials=%h", i, o_trials);
    end
    bus.clear_stats = 1'b1; tick(); bus.clear_stats = 1'b0;
    model_clear();
    // Clear coinciding with COMMIT: nothing recorded, no pulse.
    start_trial();
    bus.led = 1'b1; bus.q2 = 4'd4; bus.q1 = 4'd5; bus.q0 = 4'd6;
    tick();
    bus.measure_q = 1'b1;
    tick(); tick();
    bus.clear_stats = 1'b1;
    tick();
    bus.clear_stats = 1'b0;
    n_checks++; if ({last_bits(), best_bits(), trial_bits(), error_bits(), bus.best_valid, bus.new_best} !== 58'h0) begin n_fail++; $display("FAIL clear_commit got=%h exp=0", {last_bits(), best_bits(), trial_bits(), error_bits(), bus.best_valid, bus.new_best}); end
    tick();
    n_checks++; if (bus.new_best !== 1'b0) begin n_fail++; $display("FAIL clear_commit_pulse got=%b exp=0", bus.new_best); end
    $display("clear during commit trials=%h best_valid=%b", trial_bits(), bus.best_valid);
    bus.measure_q = 1'b0; bus.led = 1'b0;
    tick();
    // Clear coinciding with an error increment.
    start_trial();
    tick();
    bus.error_q = 1'b1; bus.clear_stats = 1'b1;
    tick();
    bus.error_q = 1'b0; bus.clear_stats = 1'b0;
    n_checks++; if (error_bits() !== 8'h00) begin n_fail++; $display("FAIL clear_error got=%h exp=00", error_bits()); end
    $display("clear during error errors=%h", error_bits());
    tick();
  endtask

  task automatic test_abort();
    start_trial();
    bus.led = 1'b1; bus.q2 = 4'd5; bus.q1 = 4'd5; bus.q0 = 4'd5;
    tick();
    bus.measure_q = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
    n_checks++; if ({last_bits(), best_bits(), trial_bits(), error_bits(), bus.best_valid, bus.new_best, bus.busy} !== 59'h0) begin n_fail++; $display("FAIL reset_mid_capture got=%h exp=0", {last_bits(), best_bits(), trial_bits(), error_bits(), bus.best_valid, bus.new_best, bus.busy}); end
    bus.measure_q = 1'b0;
    tick();
    // Abort in COMMIT.
    start_trial();
    bus.q2 = 4'd3; bus.q1 = 4'd0; bus.q0 = 4'd0;
    tick();
    bus.measure_q = 1'b1;
    tick(); tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_checks++; if ({bus.busy, bus.new_best, bus.best_valid, best_bits(), trial_bits()} !== {3'b100, 12'h0, 8'h0}) begin n_fail++; $display("FAIL abort_commit got=%h exp=%h", {bus.busy, bus.new_best, bus.best_valid, best_bits(), trial_bits()}, {3'b100, 12'h0, 8'h0}); end
    tick();
    n_checks++; if ({bus.new_best, bus.best_valid, trial_bits()} !== 10'h0) begin n_fail++; $display("FAIL abort_commit_late got=%h exp=0", {bus.new_best, bus.best_valid, trial_bits()}); end
    $display("abort in commit busy=%b trials=%h", bus.busy, trial_bits());
    bus.measure_q = 1'b0;
    tick(); tick();
    // Abort in CAPTURE: the new digits never reach last.
    bus.q2 = 4'd7; bus.q1 = 4'd7; bus.q0 = 4'd7;
    bus.measure_q = 1'b1;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    n_checks++; if (last_bits() === 12'h777) begin n_fail++; $display("FAIL abort_capture got=%h exp=not 777", last_bits()); end
    n_checks++; if ({bus.busy, trial_bits()} !== 9'h100) begin n_fail++; $display("FAIL abort_capture_state got=%h exp=100", {bus.busy, trial_bits()}); end
    $display("abort in capture last=%h busy=%b", last_bits(), bus.busy);
    bus.measure_q = 1'b0; bus.led = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_first_trial();
    test_best_tie();
    test_errors();
    test_overflow();
    test_start_priority();
    test_random();
    test_saturation();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
